// File: rtl/pack_sched_if.sv
// pack_sched_if: source-side and packer-side handshake bundle for the scheduler.
interface pack_sched_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_last;
    logic [NUM_SRC-1:0]            src_ready;
    logic                          pk_valid;
    logic [DATA_WIDTH-1:0]         pk_data;
    logic [ADDR_WIDTH-1:0]         pk_addr;
    logic                          pk_ready;
    logic [$clog2(NUM_SRC)-1:0]    grant_id;
    logic                          busy;

    modport master (
        output src_valid, src_data, src_last, pk_ready,
        input  src_ready, pk_valid, pk_data, pk_addr, grant_id, busy
    );

    modport slave (
        input  src_valid, src_data, src_last, pk_ready,
        output src_ready, pk_valid, pk_data, pk_addr, grant_id, busy
    );
endinterface

// File: rtl/pack_sched.sv
// pack_sched: round-robin burst scheduler sharing one symbol packer among NUM_SRC sources,
// stamping each accepted symbol with a sequential packet address.
module pack_sched #(
    parameter int                    NUM_SRC    = 4,
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter int                    BURST_LEN  = 8,
    parameter int                    STALL_MAX  = 16
) (
    input logic        clk,
    input logic        rst,
    pack_sched_if.slave bus
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]            state;
    logic [GW-1:0]         rr_ptr, grant, next_grant;
    logic [BW-1:0]         burst_cnt;
    logic [SW-1:0]         stall_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  busy, gvalid, xfer;

    assign busy   = state == STREAM;
    assign gvalid = bus.src_valid[grant];
    assign xfer   = busy && gvalid && bus.pk_ready;

    assign bus.busy      = busy;
    assign bus.grant_id  = grant;
    assign bus.pk_addr   = addr;
    assign bus.pk_valid  = busy && gvalid;
    assign bus.pk_data   = busy ? bus.src_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.src_ready = (busy && bus.pk_ready) ? NUM_SRC'(1) << grant : '0;

    // Scan downward so the nearest requester after rr_ptr wins; rr_ptr itself is checked last.
    always_comb begin
        next_grant = rr_ptr;
        for (int k = NUM_SRC; k >= 1; k--)
            if (bus.src_valid[(int'(rr_ptr) + k) % NUM_SRC]) next_grant = GW'((int'(rr_ptr) + k) % NUM_SRC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= GW'(NUM_SRC - 1);
            grant     <= '0;
            addr      <= START_ADDR;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE) begin
            if (|bus.src_valid) begin
                grant     <= next_grant;
                burst_cnt <= '0;
                stall_cnt <= '0;
                state     <= STREAM;
            end
        end else if (xfer) begin
            addr      <= (&addr) ? START_ADDR : addr + 1'b1;
            burst_cnt <= burst_cnt + 1'b1;
            stall_cnt <= '0;
            if (bus.src_last[grant] || burst_cnt == BW'(BURST_LEN - 1)) begin
                rr_ptr <= grant;
                state  <= IDLE;
            end
        end else if (!gvalid) begin
            // Packer backpressure (valid but not ready) deliberately leaves the stall count alone.
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == SW'(STALL_MAX - 1)) begin
                rr_ptr <= grant;
                state  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pack_sched.sv
// tb_pack_sched: randomized phases checked cycle by cycle against a behavioural scheduler model;
// a second instance with a 4-bit address starting at 3 exercises the address wrap.
module tb_pack_sched;
    localparam int N = 4;

    logic clk = 0;
    logic rst = 0;
    int   total = 0;
    int   bad = 0;

    bit   m_busy;
    int   m_grant, m_ptr, m_cnt, m_stall;
    longint m_addr, m_addr_w;

    pack_sched_if #(.NUM_SRC(N), .DATA_WIDTH(4), .ADDR_WIDTH(32)) bus ();
    pack_sched_if #(.NUM_SRC(N), .DATA_WIDTH(4), .ADDR_WIDTH(4))  bus_w ();

    assign bus_w.src_valid = bus.src_valid;
    assign bus_w.src_data  = bus.src_data;
    assign bus_w.src_last  = bus.src_last;
    assign bus_w.pk_ready  = bus.pk_ready;

    pack_sched #(.NUM_SRC(N), .DATA_WIDTH(4), .ADDR_WIDTH(32), .START_ADDR(32'd0),
                 .BURST_LEN(8), .STALL_MAX(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    pack_sched #(.NUM_SRC(N), .DATA_WIDTH(4), .ADDR_WIDTH(4), .START_ADDR(4'd3),
                 .BURST_LEN(8), .STALL_MAX(16)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_ptr = N - 1; m_cnt = 0; m_stall = 0;
        m_addr = 0; m_addr_w = 3;
    endtask

    // One clock of scheduler behaviour, stated as grant/burst/stall rules over plain integers.
    task automatic model_tick();
        bit found = 0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++)
                if (!found && bus.src_valid[(m_ptr + k) % N]) begin
                    found = 1;
                    m_grant = (m_ptr + k) % N;
                end
            if (found) begin m_busy = 1; m_cnt = 0; m_stall = 0; end
        end else if (bus.src_valid[m_grant] && bus.pk_ready) begin
            m_addr   = (m_addr + 1) % (64'd1 << 32);
            m_addr_w = (m_addr_w == 15) ? 3 : m_addr_w + 1;
            m_cnt++;
            m_stall = 0;
            if (bus.src_last[m_grant] || m_cnt == 8) begin m_ptr = m_grant; m_busy = 0; end
        end else if (!bus.src_valid[m_grant]) begin
            m_stall++;
            if (m_stall == 16) begin m_ptr = m_grant; m_busy = 0; end
        end
    endtask

    task automatic drive(input logic [N-1:0] sv, input logic [N-1:0] sl, input logic rdy);
        bus.src_valid = sv;
        bus.src_last  = sl;
        bus.pk_ready  = rdy;
        bus.src_data  = 16'($urandom);
    endtask

    task automatic step();
        logic [3:0] ed;
        #1;
        ed = 4'((bus.src_data >> (4 * m_grant)) & 16'hF);
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("grant_id", 64'(bus.grant_id), 64'(m_grant));
        chk("pk_valid", 64'(bus.pk_valid), 64'(m_busy && bus.src_valid[m_grant]));
        chk("pk_data", 64'(bus.pk_data), m_busy ? 64'(ed) : 64'd0);
        chk("src_ready", 64'(bus.src_ready), (m_busy && bus.pk_ready) ? 64'd1 << m_grant : 64'd0);
        chk("pk_addr", 64'(bus.pk_addr), 64'(m_addr));
        chk("pk_addr_wrap", 64'(bus_w.pk_addr), 64'(m_addr_w));
        chk("pk_valid_wrap", 64'(bus_w.pk_valid), 64'(bus.pk_valid));
        @(posedge clk);
        if (rst) model_tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        step();
        rst = 1;
    endtask

    initial begin
        model_reset();
        drive('0, '0, 1'b0);
        @(negedge clk);
        step();
        chk("reset_addr", 64'(bus.pk_addr), 64'd0);
        rst = 1;
        // single requester: fair 8-symbol bursts with a bubble
        for (int i = 0; i < 40; i++) begin drive(4'b0100, '0, 1'b1); step(); end
        // all sources requesting: rotation 0,1,2,3,...
        do_reset();
        for (int i = 0; i < 45; i++) begin drive(4'hF, '0, 1'b1); step(); end
        // early end-of-message
        for (int i = 0; i < 40; i++) begin drive(4'hF, 4'($urandom) & 4'($urandom), 1'b1); step(); end
        // stall timeout on source 0 while source 1 waits
        do_reset();
        drive(4'b0001, '0, 1'b1); step();
        for (int i = 0; i < 25; i++) begin drive(4'b0010, '0, 1'b1); step(); end
        // long packer backpressure mid-burst
        for (int i = 0; i < 3; i++) begin drive(4'hF, '0, 1'b1); step(); end
        for (int i = 0; i < 40; i++) begin drive(4'hF, '0, 1'b0); step(); end
        for (int i = 0; i < 12; i++) begin drive(4'hF, '0, 1'b1); step(); end
        // reset asserted mid-burst: outputs drop at once, restart from source 0
        do_reset();
        chk("post_reset_wrap_addr", 64'(bus_w.pk_addr), 64'd3);
        for (int i = 0; i < 3; i++) begin drive(4'hF, '0, 1'b1); step(); end
        // random mix with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            drive(4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 120) == 0) do_reset();
            else step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
